psk_symbol_mapper: RTL and testbench
====================================

Name: psk_symbol_mapper

Overview:
Parametrised successor to the single-word BPSK polarity stage. Accepts an N-bit codeword per handshake, with N=7 for Hamming and N=15 for BCH. Serialises it LSB-first into BPSK or QPSK symbols with signed I/Q amplitudes, optional differential encoding and a polarity-invert flag. Sits between the channel encoder (Hamming/BCH) and the channel/noise model; valid/ready on both sides.

Parameters:
N, 7, codeword width in bits (>=2; 15 for BCH)
AMP_W, 8, signed output sample width
AMP, 127, symbol magnitude; must satisfy 0 < AMP <= 2^(AMP_W-1)-1

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
DataIn  in  N  codeword; bit 0 transmitted first
InValid  in  1  DataIn/Mode/Diff/Flag valid
InReady  out  1  mapper can accept a codeword
Mode  in  1  0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol)
Diff  in  1  1 = differential encoding enabled
Flag  in  1  1 = invert output polarity
IOut  out  AMP_W  signed in-phase sample
QOut  out  AMP_W  signed quadrature sample (0 in BPSK)
SymValid  out  1  IOut/QOut hold a valid symbol
SymLast  out  1  final symbol of the current codeword
OutReady  in  1  downstream accepts the symbol

Behaviour:
- Clock is CLK. Reset RST is synchronous and active-high.
- Reset values: IOut=0, QOut=0, SymValid=0, SymLast=0, InReady=1. State is IDLE; bit counter is 0; differential refs refI=refQ=0.
- States:
  - IDLE: InReady=1. On InValid=1, latch DataIn, Mode, Diff and Flag into a shadow register and go to SHIFT with bits_left=N.
  - SHIFT: InReady=0. These inputs are sampled only at accept; later changes are ignored.
- Output register load condition: (!SymValid || OutReady) && state==SHIFT.
- On each load:
  - BPSK: take bit b0 = shreg[0]; shift right by 1; bits_left -= 1.
  - QPSK: take bI = shreg[0] and bQ = shreg[1]; shift right by 2; bits_left -= min(2, bits_left). If only one bit remains, bQ = 0 (pad).
- Differential encoding, when Diff=1, per rail: d = b XOR ref; ref <= d. QOut's rail ref is updated only in QPSK. When Diff=0, d = b and refs are unchanged.
- Refs persist across codewords. They are cleared only by RST.
- Polarity: p = d XOR Flag. p=0 -> +AMP; p=1 -> -AMP. BPSK drives QOut=0.
- SymLast=1 on the load that consumes the final bit. On that same load, state returns to IDLE.
- Symbols per codeword: N in BPSK, ceil(N/2) in QPSK.
- Latency: accept at cycle t; first SymValid=1 at t+2. With OutReady held at 1, one symbol per cycle; the next codeword can be accepted the cycle after SymLast is loaded.
- Backpressure: while SymValid=1 and OutReady=0, IOut, QOut, SymValid and SymLast are held stable and the shift register is frozen.
- SymValid drops when the last symbol is accepted and no new symbol loads.
- RST mid-word: the word is aborted, with no further symbols. Next cycle SymValid=0 and InReady=1; refs are cleared.

Decomposition:
- Package psk_pkg: MODE_BPSK=1'b0 and MODE_QPSK=1'b1 constants; state encoding IDLE/SHIFT; bit-counter width $clog2(N+1).
- Sub-module psk_rail_map, instantiated for I and Q:
  - Inputs: bit, Diff, Flag, load enable, RST.
  - Holds its ref flop and outputs the signed ±AMP sample.
  - Parameters AMP_W and AMP.

Test Plan:
1. N=7, BPSK, Diff=0, Flag=0, DataIn=7'h53, OutReady=1 -> IOut = -127,-127,+127,+127,-127,+127,-127; QOut=0; SymLast on the 7th symbol; first SymValid at accept+2.
2. Same word with Flag=1 -> all seven IOut signs inverted; then the mapper accepts the next word the cycle after SymLast loads.
3. QPSK, DataIn=7'h53 -> 4 symbols, (I,Q) = (-127,-127), (+127,+127), (-127,+127), (-127,+127); last symbol uses the padded Q bit; SymLast on the 4th.
4. BPSK, Diff=1 from reset, DataIn=7'h7F -> IOut = -,+,-,+,-,+,- (×127). Then DataIn=7'h00 -> all seven -127, because the ref is carried across words.
5. Mid-word, hold OutReady=0 for 3 cycles at the 3rd symbol -> IOut, QOut and SymLast stable, no symbol lost or duplicated, InReady=0 throughout.
6. N=15 instance: assert RST on the 5th symbol -> next cycle SymValid=0 and InReady=1. A new BPSK Diff=1 word 15'h0001 restarts from bit 0 with ref=0: first IOut=-127, then the remaining 14 symbols are -127.

Source files
------------

// File: rtl/psk_pkg.sv
// Shared constants for the PSK symbol mapper.
// Mode encoding, FSM state type, bit-counter width helper.
package psk_pkg;

  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/psk_rail_map.sv
// One I or Q rail: differential encoder ref flop plus +/-AMP mapping.
// Ports: clk, rst, load, bit_in, diff, flag in; amp (signed sample) out.
module psk_rail_map #(
  parameter int AMP_W = 8,
  parameter int AMP   = 127
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    bit_in,
  input  logic                    diff,
  input  logic                    flag,
  output logic signed [AMP_W-1:0] amp
);

  localparam logic signed [AMP_W-1:0] POS = AMP_W'(AMP);
  localparam logic signed [AMP_W-1:0] NEG = -POS;

  logic ref_q;
  logic d;

  assign d   = bit_in ^ (diff & ref_q);
  assign amp = (d ^ flag) ? NEG : POS;

  // ref only tracks the encoded stream while diff is on
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= 1'b0;
    end else if (load && diff) begin
      ref_q <= d;
    end
  end

endmodule

// File: rtl/psk_symbol_mapper.sv
// Serialises an N-bit codeword LSB-first into BPSK/QPSK I/Q symbols.
// Ports: CLK, RST, DataIn/InValid/InReady, Mode/Diff/Flag, IOut/QOut/SymValid/SymLast/OutReady.
module psk_symbol_mapper
  import psk_pkg::*;
#(
  parameter int N     = 7,
  parameter int AMP_W = 8,
  parameter int AMP   = 127
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N-1:0]            DataIn,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    Mode,
  input  logic                    Diff,
  input  logic                    Flag,
  output logic signed [AMP_W-1:0] IOut,
  output logic signed [AMP_W-1:0] QOut,
  output logic                    SymValid,
  output logic                    SymLast,
  input  logic                    OutReady
);

  localparam int CW = cnt_w(N);

  state_t state, state_nx;

  logic [N-1:0]  shreg;
  logic [CW-1:0] bits_left;
  logic [CW-1:0] step;
  logic          mode_q;
  logic          diff_q;
  logic          flag_q;
  logic          load;
  logic          last;
  logic          b_i;
  logic          b_q;
  logic          load_q;

  logic signed [AMP_W-1:0] amp_i;
  logic signed [AMP_W-1:0] amp_q;

  assign step = (mode_q == MODE_QPSK) ? CW'(2) : CW'(1);
  assign b_i  = shreg[0];
  // a lone trailing bit in QPSK pads Q with 0
  assign b_q  = (bits_left >= CW'(2)) ? shreg[1] : 1'b0;

  assign load_q = load && (mode_q == MODE_QPSK);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    InReady  = 1'b0;
    load     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) state_nx = SHIFT;
      end
      SHIFT: begin
        load = !SymValid || OutReady;
        last = load && (bits_left <= step);
        if (last) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg     <= '0;
      bits_left <= '0;
      mode_q    <= MODE_BPSK;
      diff_q    <= 1'b0;
      flag_q    <= 1'b0;
    end else if (state == IDLE && InValid) begin
      shreg     <= DataIn;
      bits_left <= CW'(N);
      mode_q    <= Mode;
      diff_q    <= Diff;
      flag_q    <= Flag;
    end else if (load) begin
      shreg     <= (mode_q == MODE_QPSK) ? shreg >> 2 : shreg >> 1;
      bits_left <= last ? '0 : bits_left - step;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      IOut     <= '0;
      QOut     <= '0;
      SymValid <= 1'b0;
      SymLast  <= 1'b0;
    end else if (load) begin
      IOut     <= amp_i;
      QOut     <= load_q ? amp_q : '0;
      SymValid <= 1'b1;
      SymLast  <= last;
    end else if (OutReady) begin
      SymValid <= 1'b0;
      SymLast  <= 1'b0;
    end
  end

  psk_rail_map #(
    .AMP_W(AMP_W),
    .AMP  (AMP)
  ) u_rail_i (
    .clk   (CLK),
    .rst   (RST),
    .load  (load),
    .bit_in(b_i),
    .diff  (diff_q),
    .flag  (flag_q),
    .amp   (amp_i)
  );

  psk_rail_map #(
    .AMP_W(AMP_W),
    .AMP  (AMP)
  ) u_rail_q (
    .clk   (CLK),
    .rst   (RST),
    .load  (load_q),
    .bit_in(b_q),
    .diff  (diff_q),
    .flag  (flag_q),
    .amp   (amp_q)
  );

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Testbench for psk_symbol_mapper: N=7 and N=15 instances.
// Table vectors, corner sequences and random words vs a reference model.
module tb_psk_symbol_mapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst  [2];
  logic                inv  [2];
  logic                mode [2];
  logic                diff [2];
  logic                flag [2];
  logic                or_r [2];
  logic                rdy  [2];
  logic                sv   [2];
  logic                sl   [2];
  logic signed [7:0]   io   [2];
  logic signed [7:0]   qo   [2];
  logic [6:0]          din7;
  logic [14:0]         din15;

  psk_symbol_mapper #(.N(7), .AMP_W(8), .AMP(127)) dut7 (
    .CLK(clk), .RST(rst[0]), .DataIn(din7),
    .InValid(inv[0]), .InReady(rdy[0]),
    .Mode(mode[0]), .Diff(diff[0]), .Flag(flag[0]),
    .IOut(io[0]), .QOut(qo[0]),
    .SymValid(sv[0]), .SymLast(sl[0]), .OutReady(or_r[0])
  );

  psk_symbol_mapper #(.N(15), .AMP_W(8), .AMP(127)) dut15 (
    .CLK(clk), .RST(rst[1]), .DataIn(din15),
    .InValid(inv[1]), .InReady(rdy[1]),
    .Mode(mode[1]), .Diff(diff[1]), .Flag(flag[1]),
    .IOut(io[1]), .QOut(qo[1]),
    .SymValid(sv[1]), .SymLast(sl[1]), .OutReady(or_r[1])
  );

  typedef struct packed {
    logic       rst_b;
    logic [6:0] data;
    logic       m;
    logic       d;
    logic       f;
    logic [3:0] nsym;
    logic [7:0] negi;
    logic [7:0] negq;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic mri [2];
  logic mrq [2];

  int   exp_i [$];
  int   exp_q [$];
  logic exp_l [$];
  int   got_i [$];
  int   got_q [$];
  logic got_l [$];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: bit k of the word goes out k-th; QPSK pairs (2k, 2k+1).
  task automatic model(input int s, input int n, input logic [14:0] w,
                       input logic m, input logic d, input logic f);
    int   ns;
    logic bi, bq, di, dq;
    ns = m ? (n + 1) / 2 : n;
    exp_i.delete(); exp_q.delete(); exp_l.delete();
    for (int k = 0; k < ns; k++) begin
      if (!m) begin
        bi = w[k];
        bq = 1'b0;
      end else begin
        bi = w[2*k];
        bq = (2*k + 1 < n) ? w[2*k+1] : 1'b0;
      end
      di = d ? (bi ^ mri[s]) : bi;
      if (d) mri[s] = di;
      exp_i.push_back((di ^ f) ? -127 : 127);
      if (m) begin
        dq = d ? (bq ^ mrq[s]) : bq;
        if (d) mrq[s] = dq;
        exp_q.push_back((dq ^ f) ? -127 : 127);
      end else begin
        exp_q.push_back(0);
      end
      exp_l.push_back(k == ns - 1);
    end
  endtask

  task automatic do_reset(input int s);
    rst[s] = 1'b1;
    @(negedge clk);
    rst[s] = 1'b0;
    mri[s] = 1'b0;
    mrq[s] = 1'b0;
  endtask

  task automatic send(input int s, input logic [14:0] w,
                      input logic m, input logic d, input logic f);
    if (s == 0) din7 = w[6:0];
    else        din15 = w;
    mode[s] = m;
    diff[s] = d;
    flag[s] = f;
    inv[s]  = 1'b1;
    check("in_ready_at_accept", int'(rdy[s]), 1);
    @(negedge clk);
    inv[s]  = 1'b0;
    mode[s] = ~m;
    diff[s] = ~d;
    flag[s] = ~f;
  endtask

  task automatic collect(input int s, input int rnd, input int stall_at,
                         input int abort_at, output int first_at,
                         output int aborted);
    int   cyc;
    int   n;
    logic done;
    logic stalled;
    int   si, sq;
    logic sll;
    cyc = 0; n = 0; done = 1'b0; stalled = 1'b0;
    first_at = -1; aborted = 0;
    got_i.delete(); got_q.delete(); got_l.delete();
    while (!done && cyc < 400) begin
      or_r[s] = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sv[s] && first_at < 0) first_at = cyc;
      if (sv[s] && n == abort_at) begin
        aborted = 1;
        done = 1'b1;
      end else if (sv[s]) begin
        if (n == stall_at && !stalled) begin
          si = int'(io[s]); sq = int'(qo[s]); sll = sl[s];
          or_r[s] = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("stall_i", int'(io[s]), si);
            check("stall_q", int'(qo[s]), sq);
            check("stall_last", int'(sl[s]), int'(sll));
            check("stall_valid", int'(sv[s]), 1);
            check("stall_in_ready", int'(rdy[s]), 0);
          end
          or_r[s] = 1'b1;
          stalled = 1'b1;
        end
        if (or_r[s]) begin
          got_i.push_back(int'(io[s]));
          got_q.push_back(int'(qo[s]));
          got_l.push_back(sl[s]);
          n++;
          if (sl[s]) begin
            check("ready_after_last", int'(rdy[s]), 1);
            done = 1'b1;
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL collect_timeout: got %0d symbols, expected SymLast", n);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_count"}, got_i.size(), exp_i.size());
    for (int k = 0; k < exp_i.size() && k < got_i.size(); k++) begin
      check({tag, "_i"}, got_i[k], exp_i[k]);
      check({tag, "_q"}, got_q[k], exp_q[k]);
      check({tag, "_last"}, int'(got_l[k]), int'(exp_l[k]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl [5];
    int   fa, ab;
    int   nn;
    logic [14:0] w;
    logic m, d, f;

    tbl[0] = '{1'b1, 7'h53, 1'b0, 1'b0, 1'b0, 4'd7, 8'h53, 8'h00};
    tbl[1] = '{1'b0, 7'h53, 1'b0, 1'b0, 1'b1, 4'd7, 8'h2C, 8'h00};
    tbl[2] = '{1'b0, 7'h53, 1'b1, 1'b0, 1'b0, 4'd4, 8'h0D, 8'h01};
    tbl[3] = '{1'b1, 7'h7F, 1'b0, 1'b1, 1'b0, 4'd7, 8'h55, 8'h00};
    tbl[4] = '{1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 4'd7, 8'h7F, 8'h00};

    din7 = '0;
    din15 = '0;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; inv[s] = 1'b0; mode[s] = 1'b0;
      diff[s] = 1'b0; flag[s] = 1'b0; or_r[s] = 1'b1;
      mri[s] = 1'b0; mrq[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check("rst_iout", int'(io[s]), 0);
      check("rst_qout", int'(qo[s]), 0);
      check("rst_symvalid", int'(sv[s]), 0);
      check("rst_symlast", int'(sl[s]), 0);
      check("rst_inready", int'(rdy[s]), 1);
    end

    for (int r = 0; r < 5; r++) begin
      if (tbl[r].rst_b) do_reset(0);
      model(0, 7, {8'h00, tbl[r].data}, tbl[r].m, tbl[r].d, tbl[r].f);
      send(0, {8'h00, tbl[r].data}, tbl[r].m, tbl[r].d, tbl[r].f);
      collect(0, 0, -1, -1, fa, ab);
      check("latency", fa, 1);
      check("tbl_count", got_i.size(), int'(tbl[r].nsym));
      for (int k = 0; k < int'(tbl[r].nsym) && k < got_i.size(); k++) begin
        check("tbl_i", got_i[k], tbl[r].negi[k] ? -127 : 127);
        check("tbl_q", got_q[k],
              !tbl[r].m ? 0 : (tbl[r].negq[k] ? -127 : 127));
        check("tbl_last", int'(got_l[k]),
              (k == int'(tbl[r].nsym) - 1) ? 1 : 0);
      end
      compare_model("tbl_model");
    end

    model(0, 7, 15'h0035, 1'b0, 1'b0, 1'b0);
    send(0, 15'h0035, 1'b0, 1'b0, 1'b0);
    collect(0, 0, 2, -1, fa, ab);
    compare_model("stall");

    send(1, 15'h5A5A, 1'b0, 1'b1, 1'b0);
    collect(1, 0, -1, 4, fa, ab);
    check("abort_reached", ab, 1);
    rst[1] = 1'b1;
    @(negedge clk);
    check("abort_symvalid", int'(sv[1]), 0);
    check("abort_inready", int'(rdy[1]), 1);
    rst[1] = 1'b0;
    mri[1] = 1'b0;
    mrq[1] = 1'b0;
    model(1, 15, 15'h0001, 1'b0, 1'b1, 1'b0);
    send(1, 15'h0001, 1'b0, 1'b1, 1'b0);
    collect(1, 0, -1, -1, fa, ab);
    check("restart_count", got_i.size(), 15);
    for (int k = 0; k < got_i.size(); k++)
      check("restart_i", got_i[k], -127);
    compare_model("restart");

    for (int s = 0; s < 2; s++) begin
      nn = (s == 0) ? 7 : 15;
      repeat (25) begin
        w = 15'($urandom);
        if (s == 0) w = w & 15'h007F;
        m = 1'($urandom_range(0, 1));
        d = 1'($urandom_range(0, 1));
        f = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        model(s, nn, w, m, d, f);
        send(s, w, m, d, f);
        collect(s, 1, -1, -1, fa, ab);
        compare_model("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
